// File: rtl/ddr_ring_pkg.sv
// rtl/ddr_ring_pkg.sv - shared types and width helpers for the DDR burst ring sequencer
package ddr_ring_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_ISSUE = 2'd2
    } chan_state_t;

    function automatic int ptr_width(input int n_bursts);
        return (n_bursts <= 1) ? 1 : $clog2(n_bursts);
    endfunction

    function automatic int lvl_width(input int n_bursts);
        return $clog2(n_bursts + 1);
    endfunction

    function automatic int burst_bytes(input int words, input int word_bytes);
        return words * word_bytes;
    endfunction

    // Widths for the default 1024-burst ring; instances derive their own from the helpers
    localparam int PTR_W = ptr_width(1024);
    localparam int LVL_W = lvl_width(1024);

endpackage

// File: rtl/ddr_ring_chan.sv
// rtl/ddr_ring_chan.sv - one ring direction: request FSM, burst pointer, address register, sticky error
module ddr_ring_chan
    import ddr_ring_pkg::*;
#(
    parameter int ADDR_W        = 30,
    parameter int BASE_ADDR     = 0,
    parameter int REGION_BURSTS = 1024,
    parameter int BURST_BYTES   = 128
) (
    input  logic              clkA_addr,
    input  logic              addr_rstA_wr,
    input  logic              i_sync_clr,
    input  logic              i_req,
    input  logic              i_can_accept,
    input  logic              i_cmd_full,
    output logic              o_ready,
    output logic              o_cmd_en,
    output logic [ADDR_W-1:0] o_cmd_addr,
    output logic              o_done,
    output logic              o_err
);

    localparam int PW = ptr_width(REGION_BURSTS);
    localparam logic [PW-1:0]     PTR_LAST = PW'(REGION_BURSTS - 1);
    localparam logic [ADDR_W-1:0] ADDR_0   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(BURST_BYTES);

    chan_state_t       r_state;
    chan_state_t       w_state_nxt;
    logic [PW-1:0]     r_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic              w_leave;

    always_ff @(posedge clkA_addr or posedge addr_rstA_wr) begin
        if (addr_rstA_wr) begin
            r_state <= ST_IDLE;
        end else if (i_sync_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_req && o_ready) w_state_nxt = ST_PEND;
            ST_PEND:  if (!i_cmd_full) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // sync_clr masks the issue cycle so a cleared burst is neither sent nor counted
    always_comb begin
        o_ready  = 1'b0;
        w_leave  = 1'b0;
        o_ready  = (r_state == ST_IDLE) && i_can_accept;
        w_leave  = (r_state == ST_ISSUE) && !i_sync_clr;
        o_cmd_en = w_leave;
        o_done   = w_leave;
    end

    always_ff @(posedge clkA_addr or posedge addr_rstA_wr) begin
        if (addr_rstA_wr) begin
            r_ptr  <= '0;
            r_addr <= ADDR_0;
            r_err  <= 1'b0;
        end else if (i_sync_clr) begin
            r_ptr  <= '0;
            r_addr <= ADDR_0;
            r_err  <= 1'b0;
        end else begin
            // Address tracks the pointer incrementally, reloading the base on wrap
            if (w_leave) begin
                if (r_ptr == PTR_LAST) begin
                    r_ptr  <= '0;
                    r_addr <= ADDR_0;
                end else begin
                    r_ptr  <= r_ptr + 1'b1;
                    r_addr <= r_addr + ADDR_INC;
                end
            end
            if (i_req && !o_ready) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_cmd_addr = r_addr;
    assign o_err      = r_err;

endmodule

// File: rtl/ddr_ring_burst_addr.sv
// rtl/ddr_ring_burst_addr.sv - ring-buffer burst address sequencer for the MCB write/read command ports
module ddr_ring_burst_addr
    import ddr_ring_pkg::*;
#(
    parameter int ADDR_W        = 30,
    parameter int BURST_WORDS   = 32,
    parameter int WORD_BYTES    = 4,
    parameter int BASE_ADDR     = 0,
    parameter int REGION_BURSTS = 1024
) (
    input  logic                                clkA_addr,
    input  logic                                addr_rstA_wr,
    input  logic                                i_sync_clr,
    input  logic                                i_wr_req,
    output logic                                o_wr_ready,
    input  logic                                i_rd_req,
    output logic                                o_rd_ready,
    output logic                                o_wr_cmd_en,
    output logic                                o_rd_cmd_en,
    output logic [ADDR_W-1:0]                   o_wr_cmd_addr,
    output logic [ADDR_W-1:0]                   o_rd_cmd_addr,
    input  logic                                i_wr_cmd_full,
    input  logic                                i_rd_cmd_full,
    output logic [5:0]                          o_cmd_bl,
    output logic [lvl_width(REGION_BURSTS)-1:0] o_level,
    output logic                                o_full,
    output logic                                o_empty,
    output logic                                o_wr_ovf,
    output logic                                o_rd_unf
);

    localparam int LW = lvl_width(REGION_BURSTS);
    localparam int BB = burst_bytes(BURST_WORDS, WORD_BYTES);
    localparam logic [LW-1:0] LVL_MAX = LW'(REGION_BURSTS);

    if (BURST_WORDS < 1 || BURST_WORDS > 64) begin : g_bad_burst
        $error("BURST_WORDS must be 1..64");
    end
    if (REGION_BURSTS < 1) begin : g_bad_region
        $error("REGION_BURSTS must be at least 1");
    end
    if ((longint'(BASE_ADDR) % longint'(BB)) != 0) begin : g_bad_align
        $error("BASE_ADDR must be burst aligned");
    end
    if (longint'(BASE_ADDR) + longint'(REGION_BURSTS) * longint'(BB) > (longint'(1) << ADDR_W)) begin : g_bad_span
        $error("ring region exceeds the MCB address space");
    end

    logic [LW-1:0] r_level;
    logic          w_wr_done;
    logic          w_rd_done;
    logic          w_wr_can;
    logic          w_rd_can;

    assign w_wr_can = (r_level < LVL_MAX);
    assign w_rd_can = (r_level != '0);

    ddr_ring_chan #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .REGION_BURSTS(REGION_BURSTS), .BURST_BYTES(BB)
    ) u_wr_chan (
        .clkA_addr(clkA_addr), .addr_rstA_wr(addr_rstA_wr), .i_sync_clr(i_sync_clr),
        .i_req(i_wr_req), .i_can_accept(w_wr_can), .i_cmd_full(i_wr_cmd_full),
        .o_ready(o_wr_ready), .o_cmd_en(o_wr_cmd_en), .o_cmd_addr(o_wr_cmd_addr),
        .o_done(w_wr_done), .o_err(o_wr_ovf)
    );

    ddr_ring_chan #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .REGION_BURSTS(REGION_BURSTS), .BURST_BYTES(BB)
    ) u_rd_chan (
        .clkA_addr(clkA_addr), .addr_rstA_wr(addr_rstA_wr), .i_sync_clr(i_sync_clr),
        .i_req(i_rd_req), .i_can_accept(w_rd_can), .i_cmd_full(i_rd_cmd_full),
        .o_ready(o_rd_ready), .o_cmd_en(o_rd_cmd_en), .o_cmd_addr(o_rd_cmd_addr),
        .o_done(w_rd_done), .o_err(o_rd_unf)
    );

    // One outstanding command per direction keeps level within 0..REGION_BURSTS
    always_ff @(posedge clkA_addr or posedge addr_rstA_wr) begin
        if (addr_rstA_wr) begin
            r_level <= '0;
        end else if (i_sync_clr) begin
            r_level <= '0;
        end else if (w_wr_done && !w_rd_done) begin
            r_level <= r_level + 1'b1;
        end else if (w_rd_done && !w_wr_done) begin
            r_level <= r_level - 1'b1;
        end
    end

    assign o_cmd_bl = 6'(BURST_WORDS - 1);
    assign o_level  = r_level;
    assign o_full   = (r_level == LVL_MAX);
    assign o_empty  = (r_level == '0);

endmodule

// File: tb/tb_ddr_ring_burst_addr.sv
// tb/tb_ddr_ring_burst_addr.sv - directed self-checking bench for ddr_ring_burst_addr
module tb_ddr_ring_burst_addr;

    logic clkA_addr;
    logic addr_rstA_wr;

    logic        a_sync_clr, a_wr_req, a_rd_req, a_wr_cmd_full, a_rd_cmd_full;
    logic        a_wr_ready, a_rd_ready, a_wr_cmd_en, a_rd_cmd_en;
    logic [29:0] a_wr_cmd_addr, a_rd_cmd_addr;
    logic [5:0]  a_cmd_bl;
    logic [2:0]  a_level;
    logic        a_full, a_empty, a_wr_ovf, a_rd_unf;

    logic        b_sync_clr, b_wr_req, b_rd_req, b_wr_cmd_full, b_rd_cmd_full;
    logic        b_wr_ready, b_rd_ready, b_wr_cmd_en, b_rd_cmd_en;
    logic [29:0] b_wr_cmd_addr, b_rd_cmd_addr;
    logic [5:0]  b_cmd_bl;
    logic [1:0]  b_level;
    logic        b_full, b_empty, b_wr_ovf, b_rd_unf;

    int n_chk;
    int n_err;

    ddr_ring_burst_addr #(
        .ADDR_W(30), .BURST_WORDS(32), .WORD_BYTES(4), .BASE_ADDR(32'h100), .REGION_BURSTS(4)
    ) u_dut_a (
        .clkA_addr(clkA_addr), .addr_rstA_wr(addr_rstA_wr), .i_sync_clr(a_sync_clr),
        .i_wr_req(a_wr_req), .o_wr_ready(a_wr_ready), .i_rd_req(a_rd_req), .o_rd_ready(a_rd_ready),
        .o_wr_cmd_en(a_wr_cmd_en), .o_rd_cmd_en(a_rd_cmd_en),
        .o_wr_cmd_addr(a_wr_cmd_addr), .o_rd_cmd_addr(a_rd_cmd_addr),
        .i_wr_cmd_full(a_wr_cmd_full), .i_rd_cmd_full(a_rd_cmd_full),
        .o_cmd_bl(a_cmd_bl), .o_level(a_level), .o_full(a_full), .o_empty(a_empty),
        .o_wr_ovf(a_wr_ovf), .o_rd_unf(a_rd_unf)
    );

    ddr_ring_burst_addr #(
        .ADDR_W(30), .BURST_WORDS(32), .WORD_BYTES(4), .BASE_ADDR(0), .REGION_BURSTS(3)
    ) u_dut_b (
        .clkA_addr(clkA_addr), .addr_rstA_wr(addr_rstA_wr), .i_sync_clr(b_sync_clr),
        .i_wr_req(b_wr_req), .o_wr_ready(b_wr_ready), .i_rd_req(b_rd_req), .o_rd_ready(b_rd_ready),
        .o_wr_cmd_en(b_wr_cmd_en), .o_rd_cmd_en(b_rd_cmd_en),
        .o_wr_cmd_addr(b_wr_cmd_addr), .o_rd_cmd_addr(b_rd_cmd_addr),
        .i_wr_cmd_full(b_wr_cmd_full), .i_rd_cmd_full(b_rd_cmd_full),
        .o_cmd_bl(b_cmd_bl), .o_level(b_level), .o_full(b_full), .o_empty(b_empty),
        .o_wr_ovf(b_wr_ovf), .o_rd_unf(b_rd_unf)
    );

    initial clkA_addr = 1'b0;
    always #5 clkA_addr = ~clkA_addr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkA_addr);
        #1;
    endtask

    task automatic burst_a(input bit do_wr, input bit do_rd, input logic [31:0] wa, input logic [31:0] ra);
        a_wr_req = do_wr;
        a_rd_req = do_rd;
        tick();
        a_wr_req = 1'b0;
        a_rd_req = 1'b0;
        if (do_wr) chk("a_wr_ready_pend", a_wr_ready, 0);
        tick();
        chk("a_wr_cmd_en_issue", a_wr_cmd_en, do_wr);
        chk("a_rd_cmd_en_issue", a_rd_cmd_en, do_rd);
        if (do_wr) chk("a_wr_cmd_addr", a_wr_cmd_addr, wa);
        if (do_rd) chk("a_rd_cmd_addr", a_rd_cmd_addr, ra);
        tick();
    endtask

    task automatic burst_b(input bit is_wr, input logic [31:0] addr);
        b_wr_req = is_wr;
        b_rd_req = !is_wr;
        tick();
        b_wr_req = 1'b0;
        b_rd_req = 1'b0;
        tick();
        if (is_wr) begin
            chk("b_wr_cmd_en", b_wr_cmd_en, 1);
            chk("b_wr_cmd_addr", b_wr_cmd_addr, addr);
        end else begin
            chk("b_rd_cmd_en", b_rd_cmd_en, 1);
            chk("b_rd_cmd_addr", b_rd_cmd_addr, addr);
        end
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        addr_rstA_wr = 1'b1;
        {a_sync_clr, a_wr_req, a_rd_req, a_wr_cmd_full, a_rd_cmd_full} = '0;
        {b_sync_clr, b_wr_req, b_rd_req, b_wr_cmd_full, b_rd_cmd_full} = '0;
        repeat (3) @(posedge clkA_addr);
        #1;
        addr_rstA_wr = 1'b0;

        chk("rst_wr_cmd_en", a_wr_cmd_en, 0);
        chk("rst_rd_cmd_en", a_rd_cmd_en, 0);
        chk("rst_wr_addr", a_wr_cmd_addr, 32'h100);
        chk("rst_rd_addr", a_rd_cmd_addr, 32'h100);
        chk("rst_wr_ready", a_wr_ready, 1);
        chk("rst_rd_ready", a_rd_ready, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_level", a_level, 0);
        chk("rst_wr_ovf", a_wr_ovf, 0);
        chk("rst_rd_unf", a_rd_unf, 0);
        chk("rst_cmd_bl", a_cmd_bl, 31);
        chk("rst_b_wr_addr", b_wr_cmd_addr, 0);
        chk("rst_b_rd_ready", b_rd_ready, 0);

        // Four writes fill the 4-burst ring at base 0x100
        burst_a(1, 0, 32'h100, 0);
        burst_a(1, 0, 32'h180, 0);
        burst_a(1, 0, 32'h200, 0);
        burst_a(1, 0, 32'h280, 0);
        chk("fill_level", a_level, 4);
        chk("fill_full", a_full, 1);
        chk("fill_wr_ready", a_wr_ready, 0);
        chk("fill_rd_ready", a_rd_ready, 1);
        chk("fill_wr_addr_wrap", a_wr_cmd_addr, 32'h100);

        a_wr_req = 1'b1;
        tick();
        a_wr_req = 1'b0;
        chk("ovf_flag", a_wr_ovf, 1);
        chk("ovf_no_en0", a_wr_cmd_en, 0);
        tick();
        chk("ovf_no_en1", a_wr_cmd_en, 0);
        tick();
        chk("ovf_no_en2", a_wr_cmd_en, 0);
        chk("ovf_level", a_level, 4);

        burst_a(0, 1, 0, 32'h100);
        burst_a(0, 1, 0, 32'h180);
        chk("pre_sim_level", a_level, 2);
        burst_a(1, 1, 32'h100, 32'h200);
        chk("sim_level", a_level, 2);
        chk("sim_wr_addr", a_wr_cmd_addr, 32'h180);
        chk("sim_rd_addr", a_rd_cmd_addr, 32'h280);

        a_sync_clr = 1'b1;
        tick();
        a_sync_clr = 1'b0;
        chk("clr_level", a_level, 0);
        chk("clr_empty", a_empty, 1);
        chk("clr_ovf", a_wr_ovf, 0);
        chk("clr_wr_addr", a_wr_cmd_addr, 32'h100);
        chk("clr_rd_addr", a_rd_cmd_addr, 32'h100);

        a_rd_req = 1'b1;
        tick();
        a_rd_req = 1'b0;
        chk("unf_flag", a_rd_unf, 1);
        chk("unf_no_en0", a_rd_cmd_en, 0);
        tick();
        chk("unf_no_en1", a_rd_cmd_en, 0);
        a_sync_clr = 1'b1;
        tick();
        a_sync_clr = 1'b0;
        chk("unf_cleared", a_rd_unf, 0);

        // Back-pressure holds the write in PEND
        a_wr_cmd_full = 1'b1;
        a_wr_req = 1'b1;
        tick();
        a_wr_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_no_en", a_wr_cmd_en, 0);
            tick();
        end
        a_wr_cmd_full = 1'b0;
        chk("bp_still_pend", a_wr_cmd_en, 0);
        tick();
        chk("bp_en", a_wr_cmd_en, 1);
        chk("bp_addr", a_wr_cmd_addr, 32'h100);
        tick();
        chk("bp_level", a_level, 1);
        chk("bp_wr_addr_adv", a_wr_cmd_addr, 32'h180);

        a_wr_req = 1'b1;
        tick();
        a_wr_req = 1'b0;
        a_sync_clr = 1'b1;
        tick();
        a_sync_clr = 1'b0;
        chk("pclr_no_en", a_wr_cmd_en, 0);
        chk("pclr_level", a_level, 0);
        chk("pclr_wr_addr", a_wr_cmd_addr, 32'h100);
        chk("pclr_wr_ready", a_wr_ready, 1);
        tick();
        chk("pclr_no_en_late", a_wr_cmd_en, 0);

        // Non-power-of-two wrap on the 3-burst ring
        for (int i = 0; i < 5; i++) begin
            burst_b(1, (i % 3) * 128);
            chk("b_level_after_wr", b_level, 1);
            burst_b(0, (i % 3) * 128);
            chk("b_level_after_rd", b_level, 0);
        end
        chk("b_empty", b_empty, 1);
        chk("b_wr_addr_final", b_wr_cmd_addr, 32'h100);

        a_wr_req = 1'b1;
        tick();
        a_wr_req = 1'b0;
        tick();
        chk("rst_issue_en", a_wr_cmd_en, 1);
        addr_rstA_wr = 1'b1;
        #1;
        chk("rst_issue_drop", a_wr_cmd_en, 0);
        tick();
        addr_rstA_wr = 1'b0;
        chk("rst_issue_level", a_level, 0);
        chk("rst_issue_ready", a_wr_ready, 1);
        tick();
        chk("rst_issue_no_en", a_wr_cmd_en, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
